// File: rtl/program_loader.sv
// Serial byte loader that writes 32-bit words into instruction memory and releases the CPU.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK = 3'd2,
`endif
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           buf_q, buf_d;
  logic [7:0]            hdr_q, hdr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  run_q, run_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  err_q, err_d;
`endif

  logic                  accept;
  logic                  word_done;
  logic                  last_word;
  logic [ADDR_WIDTH:0]   wl_next;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE, LOAD: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK:      in_ready = 1'b1;
`endif
        default:    in_ready = 1'b0;
      endcase
    end
  end

  // A byte coinciding with load_start belongs to the abandoned load.
  assign accept    = in_valid && in_ready && !load_start;
  assign word_done = accept && (state_q == LOAD) && (cnt_q == 2'd3);
  assign wl_next   = words_q + 1'b1;
  // Header 0 means a full memory, reached when the count hits 2^ADDR_WIDTH.
  assign last_word = wl_next[ADDR_WIDTH] ||
                     ((hdr_q != 8'd0) && (CW'(wl_next) == CW'(hdr_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      hdr_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      hdr_q   <= hdr_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (accept) state_d = LOAD;
        LOAD: begin
          if (word_done && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
`endif
        DONE:  state_d = DONE;
        ERROR: state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    hdr_d   = hdr_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = (state_q == DONE) && !load_start;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = (state_d == ERROR);
`endif
    if (load_start) begin
      cnt_d   = '0;
      words_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (accept && state_q == IDLE) begin
      hdr_d = in_data;
      cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else if (accept && state_q == LOAD) begin
      cnt_d = cnt_q + 2'd1;
      buf_d = {buf_q[15:0], in_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d = csum_q ^ in_data;
`endif
      if (word_done) begin
        we_d    = 1'b1;
        addr_d  = words_q[ADDR_WIDTH-1:0];
        wdata_d = {buf_q, in_data};
        words_d = wl_next;
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_run      = run_q;
  assign words_loaded = words_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_error   = err_q;
`else
  assign load_error   = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader (ADDR_WIDTH 8 and 2 instances).
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, load_start;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_run, load_error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;

  logic        reset2, in_valid2, load_start2;
  logic [7:0]  in_data2;
  logic        in_ready2, imem_we2, cpu_run2, load_error2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  words_loaded2;

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_start(load_start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  program_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .load_start(load_start2), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .cpu_run(cpu_run2),
    .load_error(load_error2), .words_loaded(words_loaded2)
  );

  typedef struct {
    logic        rst, ls, v;
    logic [7:0]  d;
    logic        rdy, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        run, err;
    logic [8:0]  wl;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, ls, v, input logic [7:0] d,
                     input logic rdy, we, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic run, err,
                     input logic [8:0] wl);
    vec_t t;
    t.rst = rst; t.ls = ls; t.v = v; t.d = d;
    t.rdy = rdy; t.we = we; t.addr = addr; t.wdata = wdata;
    t.run = run; t.err = err; t.wl = wl;
    tbl.push_back(t);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    in_valid2 = 1'b1;
    in_data2  = b;
    step();
    in_valid2 = 1'b0;
  endtask

  initial begin
    logic [63:0] got, exp;
    logic [7:0]  x;
    logic [31:0] w;

    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    reset2 = 1'b1; load_start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h00;

    // reset, two-word load with a gap
    add(1,0,0,8'h00, 0,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h02, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h20, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h01, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,0,8'h77, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h00, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h05, 1,1,8'h00,32'h20010005,0,0,1);
    add(0,0,1,8'h8C, 1,0,8'h00,32'h20010005,0,0,1);
    add(0,0,1,8'h02, 1,0,8'h00,32'h20010005,0,0,1);
    add(0,0,1,8'h00, 1,0,8'h00,32'h20010005,0,0,1);
    add(0,0,1,8'h00, CK,1,8'h01,32'h8C020000,0,0,2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(0,0,1,8'hAA, 0,0,8'h01,32'h8C020000,0,0,2);
`endif
    // DONE: valid held high, nothing consumed
    add(0,0,1,8'hFF, 0,0,8'h01,32'h8C020000,1,0,2);
    add(0,0,1,8'hFF, 0,0,8'h01,32'h8C020000,1,0,2);
    // load_start with a coincident byte
    add(0,1,1,8'h01, 1,0,8'h01,32'h8C020000,0,0,0);
    // partial word with toggling valid, then abandon
    add(0,0,1,8'h01, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hAA, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,0,8'h00, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hBB, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,0,8'h00, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,1,1,8'hCC, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'h01, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hDE, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hAD, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hBE, 1,0,8'h01,32'h8C020000,0,0,0);
    add(0,0,1,8'hEF, CK,1,8'h00,32'hDEADBEEF,0,0,1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(0,0,1,8'h22, 0,0,8'h00,32'hDEADBEEF,0,0,1);
`endif
    add(0,0,0,8'h00, 0,0,8'h00,32'hDEADBEEF,1,0,1);
    // reset beats valid; reset mid-load discards progress
    add(1,0,1,8'h01, 0,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h01, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h11, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h22, 1,0,8'h00,32'h0,0,0,0);
    add(1,0,1,8'h33, 0,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h01, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h10, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h20, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h30, 1,0,8'h00,32'h0,0,0,0);
    add(0,0,1,8'h40, CK,1,8'h00,32'h10203040,0,0,1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(0,0,1,8'h40, 0,0,8'h00,32'h10203040,0,0,1);
`endif
    add(0,0,0,8'h00, 0,0,8'h00,32'h10203040,1,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; load_start = tbl[i].ls;
      in_valid = tbl[i].v; in_data = tbl[i].d;
      step();
      got = {11'd0, in_ready, imem_we, imem_addr, imem_wdata,
             cpu_run, load_error, words_loaded};
      exp = {11'd0, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].run, tbl[i].err, tbl[i].wl};
      chk($sformatf("row%0d", i), got, exp);
    end
    reset = 1'b0; load_start = 1'b0; in_valid = 1'b0;

    // single-word load 12345678, good checksum / error path
    load_start = 1'b1; step(); load_start = 1'b0;
    send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("w0_we", 64'(imem_we), 64'd1);
    chk("w0_data", 64'(imem_wdata), 64'h12345678);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h08); step();
    chk("ck_ok_run", 64'(cpu_run), 64'd1);
    chk("ck_ok_err", 64'(load_error), 64'd0);
    load_start = 1'b1; step(); load_start = 1'b0;
    send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    chk("ck_bad_err", 64'(load_error), 64'd1);
    step();
    chk("ck_bad_err2", 64'(load_error), 64'd1);
    chk("ck_bad_run", 64'(cpu_run), 64'd0);
    chk("ck_bad_rdy", 64'(in_ready), 64'd0);
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("ck_ls_err", 64'(load_error), 64'd0);
    chk("ck_ls_rdy", 64'(in_ready), 64'd1);
`else
    step();
    chk("nock_run", 64'(cpu_run), 64'd1);
    send(8'h09);
    chk("nock_err", 64'(load_error), 64'd0);
    chk("nock_rdy", 64'(in_ready), 64'd0);
    chk("nock_wl", 64'(words_loaded), 64'd1);
`endif

    // ADDR_WIDTH=2, header 0 means four words
    step();
    reset2 = 1'b0;
    chk("aw2_rst_wl", 64'(words_loaded2), 64'd0);
    send2(8'h00);
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      x = x ^ 8'(8'hA0 + k);
      send2(8'(8'hA0 + k));
      if (k % 4 == 3) begin
        w = {8'(8'hA0 + k - 3), 8'(8'hA0 + k - 2),
             8'(8'hA0 + k - 1), 8'(8'hA0 + k)};
        chk($sformatf("aw2_we%0d", k / 4), 64'(imem_we2), 64'd1);
        chk($sformatf("aw2_addr%0d", k / 4), 64'(imem_addr2), 64'(k / 4));
        chk($sformatf("aw2_data%0d", k / 4), 64'(imem_wdata2), 64'(w));
      end else begin
        chk($sformatf("aw2_nowe%0d", k), 64'(imem_we2), 64'd0);
      end
    end
    chk("aw2_wl", 64'(words_loaded2), 64'd4);
    if (CK) send2(x);
    step();
    chk("aw2_run", 64'(cpu_run2), 64'd1);
    chk("aw2_rdy", 64'(in_ready2), 64'd0);
    chk("aw2_err", 64'(load_error2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
